burst_rr_arbiter: RTL and testbench

BURST_RR_ARBITER -- requirements
Module: burst_rr_arbiter

---
 rtl/burst_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_burst_rr_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/burst_rr_arbiter.sv
// Burst round-robin arbiter.
// Grants one requester at a time for a tenure of up to MAX_BURST beats,
// then rotates priority starting just after the previous owner. A stall
// freezes the whole arbiter. Grant is registered, so a request seen on
// one edge produces its grant on the outputs after that edge.
module burst_rr_arbiter #(
  parameter int CLIENTS   = 8,
  parameter int MAX_BURST = 4,
  localparam int IDW      = (CLIENTS > 1) ? $clog2(CLIENTS) : 1,
  localparam int BW       = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CLIENTS-1:0] request,
  input  logic               stall,
  output logic [CLIENTS-1:0] grant,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant_id,
  output logic [BW-1:0]      beat_count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Beat index at which the tenure ends and the arbiter must rotate.
  localparam logic [BW-1:0]      BEAT_LAST  = BW'(MAX_BURST - 1);
  localparam logic [CLIENTS-1:0] GRANT_ONE  = CLIENTS'(1);
  // Out of reset the pointer sits on the last client so client 0 wins first.
  localparam logic [IDW-1:0]     LAST_RESET = IDW'(CLIENTS - 1);

  state_e               state_q, state_d;
  logic [CLIENTS-1:0]   grant_q, grant_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [IDW-1:0]       last_q,  last_d;
  logic [BW-1:0]        beat_q,  beat_d;

  // Round-robin search results.
  logic [IDW-1:0]       search_ptr;
  logic                 pick_found;
  logic [IDW-1:0]       pick_id;

  // State register: synchronous reset overrides stall and any tenure.
  always_ff @(posedge clock) begin
    // NOTE: every register in a clocked block uses <=, so all of them update
    // from the same pre-edge values and the order of statements is irrelevant.
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= LAST_RESET;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // Round-robin search: ptr+1, ptr+2, ... wrapping, with ptr itself last.
  // While BUSY the pointer is the current owner, which becomes last_owner
  // on the same edge the new selection is taken.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_id;
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    cand       = 0;
    cand_id    = '0;
    pick_found = 1'b0;
    pick_id    = '0;
    search_ptr = (state_q == ST_BUSY) ? owner_q : last_q;
    for (int k = 0; k < CLIENTS; k++) begin
      cand = int'(search_ptr) + 1 + k;
      if (cand >= CLIENTS) begin
        cand = cand - CLIENTS;
      end
      cand_id = IDW'(cand);
      if (!pick_found && request[cand_id]) begin
        pick_found = 1'b1;
        pick_id    = cand_id;
      end
    end
  end

  // Next-state: start, continue or rotate a tenure, or hold under stall.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!stall && pick_found) begin
          state_d = ST_BUSY;
          grant_d = GRANT_ONE << pick_id;
          owner_d = pick_id;
          beat_d  = '0;
        end
      end
      ST_BUSY: begin
        if (!stall) begin
          if (request[owner_q] && (beat_q < BEAT_LAST)) begin
            // Owner keeps the bus for another beat.
            beat_d = beat_q + 1'b1;
          end else begin
            // Tenure over: rotate priority and hand over without a bubble.
            last_d = owner_q;
            beat_d = '0;
            if (pick_found) begin
              grant_d = GRANT_ONE << pick_id;
              owner_d = pick_id;
            end else begin
              state_d = ST_IDLE;
              grant_d = '0;
              owner_d = '0;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        owner_d = '0;
        beat_d  = '0;
      end
    endcase
  end

  // Outputs: all driven straight from registers.
  always_comb begin
    grant       = grant_q;
    grant_valid = |grant_q;
    grant_id    = owner_q;
    beat_count  = beat_q;
  end

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Self-checking bench for burst_rr_arbiter with CLIENTS=8, MAX_BURST=4.
// Each step drives inputs on the falling edge, pushes the hand-derived
// expected outputs to a scoreboard, and pops/compares them after the
// following rising edge.
module tb_burst_rr_arbiter;

  localparam int CLIENTS   = 8;
  localparam int MAX_BURST = 4;
  localparam int IDW       = 3;
  localparam int BW        = 3;

  logic               clock = 1'b0;
  logic               reset;
  logic               stall;
  logic [CLIENTS-1:0] request;
  logic [CLIENTS-1:0] grant;
  logic               grant_valid;
  logic [IDW-1:0]     grant_id;
  logic [BW-1:0]      beat_count;

  burst_rr_arbiter #(
    .CLIENTS  (CLIENTS),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .request    (request),
    .stall      (stall),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .beat_count (beat_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic               rst;
    logic               stl;
    logic [CLIENTS-1:0] req;
    logic [CLIENTS-1:0] g;
    logic [BW-1:0]      b;
  } vec_t;

  typedef struct {
    logic [CLIENTS-1:0] g;
    logic [BW-1:0]      b;
    string              tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [IDW-1:0] id_of(input logic [CLIENTS-1:0] g);
    logic [IDW-1:0] id;
    id = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (g[i]) id = IDW'(i);
    end
    return id;
  endfunction

  function automatic void add(input logic rst, input logic stl, input logic [CLIENTS-1:0] req,
                              input logic [CLIENTS-1:0] g, input logic [BW-1:0] b);
    vec_t v;
    v.rst = rst;
    v.stl = stl;
    v.req = req;
    v.g   = g;
    v.b   = b;
    tbl.push_back(v);
  endfunction

  // One clock: drive, record expectation, wait for the edge, compare.
  task automatic step(input logic rst, input logic stl, input logic [CLIENTS-1:0] req,
                      input logic [CLIENTS-1:0] g, input logic [BW-1:0] b, input string tag);
    exp_t e;
    @(negedge clock);
    reset   = rst;
    stall   = stl;
    request = req;
    e.g   = g;
    e.b   = b;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({e.tag, " grant"},       32'(grant),       32'(e.g));
    check({e.tag, " grant_valid"}, 32'(grant_valid), 32'(|e.g));
    check({e.tag, " grant_id"},    32'(grant_id),    32'(id_of(e.g)));
    check({e.tag, " beat_count"},  32'(beat_count),  32'(e.b));
  endtask

  // Invariants checked every cycle once out of the initial reset.
  always @(negedge clock) begin
    if (mon_en) begin
      check("onehot0", 32'($onehot0(grant)), 32'd1);
      check("beat_max", 32'(beat_count <= BW'(MAX_BURST - 1)), 32'd1);
    end
  end

  initial begin
    logic [CLIENTS-1:0] g1;
    reset   = 1'b1;
    stall   = 1'b0;
    request = '0;

    // Reset rows.
    add(1, 0, 8'h00, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0);
    // Single requester: 4-beat tenure then immediate re-grant.
    for (int b = 0; b < 4; b++) add(0, 0, 8'h01, 8'h01, BW'(b));
    add(0, 0, 8'h01, 8'h01, 0);
    add(0, 0, 8'h01, 8'h01, 1);
    add(0, 0, 8'h00, 8'h00, 0);
    add(0, 0, 8'h00, 8'h00, 0);
    // last_owner is now 0, so from IDLE client 1 beats client 0.
    add(0, 0, 8'h03, 8'h02, 0);
    add(0, 0, 8'h00, 8'h00, 0);
    // Two requesters alternate with no idle bubble.
    add(1, 0, 8'h00, 8'h00, 0);
    for (int b = 0; b < 4; b++) add(0, 0, 8'h05, 8'h01, BW'(b));
    for (int b = 0; b < 4; b++) add(0, 0, 8'h05, 8'h04, BW'(b));
    add(0, 0, 8'h05, 8'h01, 0);
    add(0, 0, 8'h05, 8'h01, 1);
    add(0, 0, 8'h00, 8'h00, 0);
    // Owner 2 drops after 2 beats, client 5 takes over.
    add(1, 0, 8'h00, 8'h00, 0);
    add(0, 0, 8'h24, 8'h04, 0);
    add(0, 0, 8'h24, 8'h04, 1);
    add(0, 0, 8'h20, 8'h20, 0);
    add(0, 0, 8'h20, 8'h20, 1);
    add(0, 0, 8'h00, 8'h00, 0);
    // All clients requesting: 0..7 then 0, 4 beats each.
    add(1, 0, 8'h00, 8'h00, 0);
    for (int c = 0; c < CLIENTS; c++) begin
      g1 = 8'h01 << c;
      for (int b = 0; b < 4; b++) add(0, 0, 8'hFF, g1, BW'(b));
    end
    add(0, 0, 8'hFF, 8'h01, 0);
    add(0, 0, 8'h00, 8'h00, 0);

    step(tbl[0].rst, tbl[0].stl, tbl[0].req, tbl[0].g, tbl[0].b, "vec0");
    mon_en = 1'b1;
    for (int i = 1; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].stl, tbl[i].req, tbl[i].g, tbl[i].b, $sformatf("vec%0d", i));
    end

    // Stall in IDLE, then stall mid-tenure at beat 1 for 3 cycles.
    step(1, 0, 8'h00, 8'h00, 0, "st_rst");
    step(0, 1, 8'h01, 8'h00, 0, "st_idle");
    step(0, 0, 8'h01, 8'h01, 0, "st_b0");
    step(0, 0, 8'h01, 8'h01, 1, "st_b1");
    for (int i = 0; i < 3; i++) step(0, 1, 8'hFF, 8'h01, 1, $sformatf("st_hold%0d", i));
    step(0, 0, 8'h01, 8'h01, 2, "st_b2");
    step(0, 0, 8'h01, 8'h01, 3, "st_b3");
    step(0, 0, 8'h00, 8'h00, 0, "st_end");

    // Reset during a client-6 tenure, overriding stall.
    step(1, 0, 8'h00, 8'h00, 0, "rs_rst");
    step(0, 0, 8'h40, 8'h40, 0, "rs_b0");
    step(0, 0, 8'h40, 8'h40, 1, "rs_b1");
    step(1, 1, 8'h40, 8'h00, 0, "rs_mid");
    for (int b = 0; b < 4; b++) step(0, 0, 8'hC0, 8'h40, BW'(b), $sformatf("rs_c6_%0d", b));
    step(0, 0, 8'hC0, 8'h80, 0, "rs_c7");
    step(0, 0, 8'h00, 8'h00, 0, "rs_end");

    mon_en = 1'b0;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
